addr_seq_ctrl: RTL and testbench

Playback controller for the 4-bit address path feeding the 16-word display/pattern memory.
Sequences the address through a programmable window [lo_addr..hi_addr] at the rate of the divider tick, up or down, one-shot or looping.
Provides start, stop/pause and single-step control from the debounced front-panel buttons.
Supersedes the free-running address counter wherever range and stop control are needed.

---
 rtl/addr_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_addr_seq_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/addr_seq_ctrl.sv
// Playback address sequencer: walks Addr through a latched window [first..last]
// on divider ticks or single steps, with run/pause/done control from front-panel pulses.
module addr_seq_ctrl #(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          tick,
   input  logic          start,
   input  logic          stop,
   input  logic          step,
   input  logic          loop_en,
   input  logic          dir,
   input  logic [AW-1:0] lo_addr,
   input  logic [AW-1:0] hi_addr,
   output logic [AW-1:0] Addr,
   output logic [1:0]    state,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      DONE  = 2'b11
   } state_t;

   localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

   state_t        state_r, state_s;
   logic [AW-1:0] addr_r, addr_s;
   logic [AW-1:0] first_r, first_s;
   logic [AW-1:0] last_r, last_s;
   logic          dir_r, dir_s;
   logic          done_r;

   state_t        adv_state_s;
   logic [AW-1:0] adv_addr_s;
   logic [AW-1:0] lat_first_s;
   logic [AW-1:0] lat_last_s;

   // One advance event: step the address, or apply the end-of-window rule
   always_comb begin
      adv_state_s = state_r;
      adv_addr_s  = addr_r;
      if (addr_r == last_r) begin
         if (loop_en) begin
            adv_addr_s = first_r;
         end else begin
            adv_state_s = DONE;
         end
      end else if (dir_r) begin
         adv_addr_s = addr_r - ONE;
      end else begin
         adv_addr_s = addr_r + ONE;
      end
   end

   // Window endpoints as they would be captured by a fresh start
   always_comb begin
      if (dir) begin
         lat_first_s = hi_addr;
         lat_last_s  = lo_addr;
      end else begin
         lat_first_s = lo_addr;
         lat_last_s  = hi_addr;
      end
   end

   // Next-state decode; stop outranks start, start outranks step, step outranks tick
   always_comb begin
      state_s = state_r;
      addr_s  = addr_r;
      first_s = first_r;
      last_s  = last_r;
      dir_s   = dir_r;
      case (state_r)
         IDLE: begin
            if (start || step) begin
               first_s = lat_first_s;
               last_s  = lat_last_s;
               dir_s   = dir;
               addr_s  = lat_first_s;
               state_s = start ? RUN : PAUSE;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (stop) begin
               state_s = PAUSE;
            end else if (tick) begin
               state_s = adv_state_s;
               addr_s  = adv_addr_s;
            end else begin
               state_s = RUN;
            end
         end
         PAUSE: begin
            if (stop) begin
               state_s = IDLE;
            end else if (start) begin
               state_s = RUN;
            end else if (step) begin
               state_s = adv_state_s;
               addr_s  = adv_addr_s;
            end else begin
               state_s = PAUSE;
            end
         end
         DONE: begin
            if (stop) begin
               state_s = IDLE;
            end else if (start) begin
               first_s = lat_first_s;
               last_s  = lat_last_s;
               dir_s   = dir;
               addr_s  = lat_first_s;
               state_s = RUN;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, address and latch registers; done marks only the first DONE cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         addr_r  <= {AW{1'b0}};
         first_r <= {AW{1'b0}};
         last_r  <= {AW{1'b0}};
         dir_r   <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         addr_r  <= addr_s;
         first_r <= first_s;
         last_r  <= last_s;
         dir_r   <= dir_s;
         done_r  <= (state_s == DONE) && (state_r != DONE);
      end
   end

   assign Addr  = addr_r;
   assign state = state_r;
   assign busy  = (state_r == RUN);
   assign done  = done_r;

endmodule

// File: tb/tb_addr_seq_ctrl.sv
// Directed bench for addr_seq_ctrl: inputs change on the falling edge,
// outputs are compared on the next falling edge against hand-computed values.
module tb_addr_seq_ctrl;

   logic       clk;
   logic       reset;
   logic       tick, start, stop, step, loop_en, dir;
   logic [3:0] lo_addr, hi_addr;
   logic [3:0] Addr;
   logic [1:0] state;
   logic       busy, done;

   int err_cnt;
   int chk_cnt;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_PAUSE = 2'b10;
   localparam logic [1:0] S_DONE  = 2'b11;

   addr_seq_ctrl #(.AW(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .start   (start),
      .stop    (stop),
      .step    (step),
      .loop_en (loop_en),
      .dir     (dir),
      .lo_addr (lo_addr),
      .hi_addr (hi_addr),
      .Addr    (Addr),
      .state   (state),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive one cycle of control pulses, then return on the next falling edge
   task automatic cyc(input logic st, input logic sp, input logic sq, input logic tk);
      start = st;
      stop  = sp;
      step  = sq;
      tick  = tk;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      step  = 1'b0;
      tick  = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [3:0] ea, input logic [1:0] es, input logic ed);
      check_eq({tag, ".addr"}, {4'd0, Addr}, {4'd0, ea});
      check_eq({tag, ".state"}, {6'd0, state}, {6'd0, es});
      check_eq({tag, ".done"}, {7'd0, done}, {7'd0, ed});
      check_eq({tag, ".busy"}, {7'd0, busy}, {7'd0, (es == S_RUN)});
   endtask

   logic [3:0] exp3 [6];

   initial begin
      err_cnt = 0;
      chk_cnt = 0;
      reset = 1'b1;
      tick = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
      loop_en = 1'b0; dir = 1'b0; lo_addr = 4'd0; hi_addr = 4'd0;
      exp3 = '{4'd0, 4'd15, 4'd14, 4'd1, 4'd0, 4'd15};
      @(negedge clk);
      @(negedge clk);
      chk("por", 4'd0, S_IDLE, 1'b0);
      reset = 1'b0;

      // 1: reset mid-run
      lo_addr = 4'd0; hi_addr = 4'd15;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t1.run7", 4'd7, S_RUN, 1'b0);
      reset = 1'b1;
      tick = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tick = 1'b0;
      chk("t1.rst", 4'd0, S_IDLE, 1'b0);

      // 2: one-shot up 3..6
      lo_addr = 4'd3; hi_addr = 4'd6; dir = 1'b0; loop_en = 1'b0;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t2.start", 4'd3, S_RUN, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b1);
         chk("t2.tick", 4'(3 + i), S_RUN, 1'b0);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t2.end", 4'd6, S_DONE, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t2.hold", 4'd6, S_DONE, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t2.tick5", 4'd6, S_DONE, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("t2.stop", 4'd6, S_IDLE, 1'b0);

      // 3: looping down through the 15->0 wrap; inputs scrambled after start
      lo_addr = 4'd14; hi_addr = 4'd1; dir = 1'b1; loop_en = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t3.start", 4'd1, S_RUN, 1'b0);
      lo_addr = 4'd5; hi_addr = 4'd5; dir = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b1);
         chk("t3.tick", exp3[i], S_RUN, 1'b0);
      end
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("t3.abort", 4'd15, S_IDLE, 1'b0);

      // 4: pause with simultaneous tick, step, resume without re-latch
      lo_addr = 4'd2; hi_addr = 4'd10; dir = 1'b0; loop_en = 1'b0;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t4.at4", 4'd4, S_RUN, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      chk("t4.pause", 4'd4, S_PAUSE, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t4.tickign", 4'd4, S_PAUSE, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t4.step", 4'd5, S_PAUSE, 1'b0);
      lo_addr = 4'd9;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t4.resume", 4'd5, S_RUN, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t4.tick", 4'd6, S_RUN, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("t4.abort", 4'd6, S_IDLE, 1'b0);

      // 5: single-address window
      lo_addr = 4'd8; hi_addr = 4'd8; loop_en = 1'b0;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t5.start", 4'd8, S_RUN, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t5.done", 4'd8, S_DONE, 1'b1);
      loop_en = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t5.restart", 4'd8, S_RUN, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b1);
         chk("t5.loop", 4'd8, S_RUN, 1'b0);
      end
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);

      // 6: priority and DONE handling
      lo_addr = 4'd1; hi_addr = 4'd2; dir = 1'b0; loop_en = 1'b0;
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      chk("t6.startstep", 4'd1, S_RUN, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t6.done", 4'd2, S_DONE, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t6.stepign", 4'd2, S_DONE, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("t6.stop", 4'd2, S_IDLE, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t6.idlestep", 4'd1, S_PAUSE, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t6.step2", 4'd2, S_PAUSE, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t6.stepdone", 4'd2, S_DONE, 1'b1);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
